// File: rtl/uart_controller.sv
// Memory-mapped UART: oversampled serial receiver feeding a small RX FIFO,
// and a single-byte transmitter, exposed through a four-register bus window.
module uart_controller #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset2,
  input  logic        ren,
  input  logic        wen,
  input  logic [1:0]  address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        rx_irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CLK_W = $clog2(CLKS_PER_BIT);
  localparam logic [CLK_W-1:0] BIT_END  = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [CLK_W-1:0] HALF_END = CLK_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  logic             r_rxSync1, r_rxSync2;
  logic [1:0]       r_rxState;
  logic [CLK_W-1:0] r_rxClk;
  logic [2:0]       r_rxBitCnt;
  logic [7:0]       r_rxShift;

  logic [7:0]       r_fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wrPtr, r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             r_overrun, r_frameErr;

  logic [1:0]       r_txState;
  logic [CLK_W-1:0] r_txClk;
  logic [2:0]       r_txBitCnt;
  logic [7:0]       r_txShift;
  logic             r_tx;

  logic w_rxDone, w_stopOk, w_frameBad;
  logic w_empty, w_full, w_push, w_pop, w_statusWr;
  logic w_txBusy, w_txStart;
  logic w_unusedData;

  assign w_unusedData = ^data_in[31:8];

  // The line is asynchronous; reset to the idle level so no false start appears.
  always_ff @(posedge clk or posedge reset2) begin
    if (reset2) begin
      r_rxSync1 <= 1'b1;
      r_rxSync2 <= 1'b1;
    end else begin
      r_rxSync1 <= uart_rx;
      r_rxSync2 <= r_rxSync1;
    end
  end

  always_ff @(posedge clk or posedge reset2) begin
    if (reset2) begin
      r_rxState  <= RX_IDLE;
      r_rxClk    <= '0;
      r_rxBitCnt <= '0;
      r_rxShift  <= '0;
    end else begin
      case (r_rxState)
        RX_IDLE: begin
          if (!r_rxSync2) begin
            r_rxState  <= RX_START;
            r_rxClk    <= '0;
            r_rxBitCnt <= '0;
          end
        end
        RX_START: begin
          if (r_rxClk == HALF_END) begin
            r_rxClk   <= '0;
            r_rxState <= r_rxSync2 ? RX_IDLE : RX_DATA;
          end else begin
            r_rxClk <= r_rxClk + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_rxClk == BIT_END) begin
            r_rxClk    <= '0;
            r_rxShift  <= {r_rxSync2, r_rxShift[7:1]};
            r_rxBitCnt <= r_rxBitCnt + 3'd1;
            if (r_rxBitCnt == 3'd7) r_rxState <= RX_STOP;
          end else begin
            r_rxClk <= r_rxClk + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_rxClk == BIT_END) begin
            r_rxClk   <= '0;
            r_rxState <= RX_IDLE;
          end else begin
            r_rxClk <= r_rxClk + 1'b1;
          end
        end
        default: r_rxState <= RX_IDLE;
      endcase
    end
  end

  assign w_rxDone   = (r_rxState == RX_STOP) && (r_rxClk == BIT_END);
  assign w_stopOk   = w_rxDone && r_rxSync2;
  assign w_frameBad = w_rxDone && !r_rxSync2;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop      = ren && (address == 2'd0) && !w_empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the byte.
  assign w_push     = w_stopOk && (!w_full || w_pop);
  assign w_statusWr = wen && (address == 2'd1);

  always_ff @(posedge clk) begin
    if (w_push) r_fifoMem[r_wrPtr] <= r_rxShift;
  end

  always_ff @(posedge clk or posedge reset2) begin
    if (reset2) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overrun  <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_overrun  <= (r_overrun && !(w_statusWr && data_in[2])) ||
                    (w_stopOk && w_full && !w_pop);
      r_frameErr <= (r_frameErr && !(w_statusWr && data_in[3])) || w_frameBad;
    end
  end

  assign w_txBusy  = (r_txState != TX_IDLE);
  assign w_txStart = wen && (address == 2'd2) && !w_txBusy;

  // Every TX state lasts one full bit period; the line level is set on entry.
  always_ff @(posedge clk or posedge reset2) begin
    if (reset2) begin
      r_txState  <= TX_IDLE;
      r_txClk    <= '0;
      r_txBitCnt <= '0;
      r_txShift  <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_txState)
        TX_IDLE: begin
          if (w_txStart) begin
            r_txState <= TX_START;
            r_txShift <= data_in[7:0];
            r_txClk   <= '0;
            r_tx      <= 1'b0;
          end
        end
        TX_START: begin
          if (r_txClk == BIT_END) begin
            r_txClk    <= '0;
            r_txBitCnt <= '0;
            r_txState  <= TX_DATA;
            r_tx       <= r_txShift[0];
          end else begin
            r_txClk <= r_txClk + 1'b1;
          end
        end
        TX_DATA: begin
          if (r_txClk == BIT_END) begin
            r_txClk <= '0;
            if (r_txBitCnt == 3'd7) begin
              r_txState <= TX_STOP;
              r_tx      <= 1'b1;
            end else begin
              r_tx       <= r_txShift[1];
              r_txShift  <= r_txShift >> 1;
              r_txBitCnt <= r_txBitCnt + 3'd1;
            end
          end else begin
            r_txClk <= r_txClk + 1'b1;
          end
        end
        TX_STOP: begin
          if (r_txClk == BIT_END) begin
            r_txClk   <= '0;
            r_txState <= TX_IDLE;
          end else begin
            r_txClk <= r_txClk + 1'b1;
          end
        end
        default: r_txState <= TX_IDLE;
      endcase
    end
  end

  always_comb begin
    data_out = '0;
    case (address)
      2'd0: if (!w_empty) data_out = {24'b0, r_fifoMem[r_rdPtr]};
      2'd1: data_out = {16'b0, 8'(r_count), 3'b0, w_txBusy, r_frameErr,
                        r_overrun, w_full, !w_empty};
      default: data_out = '0;
    endcase
  end

  assign rx_irq  = !w_empty;
  assign uart_tx = r_tx;

endmodule

// File: tb/tb_uart_controller.sv
// Scoreboard bench for uart_controller: bus reads and serial TX frames are
// queued as expectations and checked by independent monitor processes.
module tb_uart_controller;

  logic        clk;
  logic        reset2;
  logic        ren;
  logic        wen;
  logic [1:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        uart_rx;
  logic        uart_tx;
  logic        rx_irq;

  int total = 0;
  int bad   = 0;

  logic [31:0] expValQ [$];
  string       expNameQ [$];
  logic [7:0]  txQ [$];

  uart_controller #(.CLKS_PER_BIT(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset2(reset2), .ren(ren), .wen(wen), .address(address),
    .data_in(data_in), .data_out(data_out), .uart_rx(uart_rx),
    .uart_tx(uart_tx), .rx_irq(rx_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busRead(input logic [1:0] addr, input logic [31:0] expected,
                         input string name);
    address = addr;
    ren     = 1'b1;
    expValQ.push_back(expected);
    expNameQ.push_back(name);
    tick();
    ren = 1'b0;
  endtask

  task automatic busWrite(input logic [1:0] addr, input logic [31:0] value);
    address = addr;
    data_in = value;
    wen     = 1'b1;
    tick();
    wen = 1'b0;
  endtask

  task automatic sendRxByte(input logic [7:0] value, input logic stopBit);
    logic [9:0] frame;
    frame = {stopBit, value, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = frame[i];
      repeat (8) tick();
    end
  endtask

  // Bus read monitor: data_out is sampled mid-cycle while the read strobe is up.
  always @(negedge clk) begin
    if (ren) begin
      if (expValQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected read: got 0x%0h expected no read", data_out);
      end else begin
        checkOutput(expNameQ.pop_front(), data_out, expValQ.pop_front());
      end
    end
  end

  // TX monitor: on a start bit, sample the middle of each of the ten bit periods.
  initial begin : txMonitor
    logic [9:0] got;
    bit aborted;
    logic [7:0] expByte;
    forever begin
      @(negedge clk);
      if (!reset2 && uart_tx === 1'b0) begin
        got = '0;
        aborted = 1'b0;
        for (int k = 0; k < 10; k++) begin
          repeat ((k == 0) ? 4 : 8) begin
            @(negedge clk);
            if (reset2) aborted = 1'b1;
          end
          got[k] = uart_tx;
        end
        if (!aborted) begin
          if (txQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected tx frame: got 0x%0h expected none", got);
          end else begin
            expByte = txQ.pop_front();
            checkOutput("tx frame", {22'b0, got}, {22'b0, 1'b1, expByte, 1'b0});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation hung");
  end

  task automatic applyStimulus();
    int cnt;

    reset2  = 1'b1;
    ren     = 1'b0;
    wen     = 1'b0;
    address = 2'd0;
    data_in = '0;
    uart_rx = 1'b1;
    repeat (3) tick();
    checkOutput("reset uart_tx", {31'b0, uart_tx}, 32'd1);
    checkOutput("reset rx_irq", {31'b0, rx_irq}, 32'd0);
    reset2 = 1'b0;
    tick();
    for (int a = 0; a < 4; a++) busRead(2'(a), 32'h0, "reset read");

    $display("[TB] single byte 0x55");
    sendRxByte(8'h55, 1'b1);
    checkOutput("rx_irq after byte", {31'b0, rx_irq}, 32'd1);
    busRead(2'd1, 32'h0101, "status one byte");
    busRead(2'd0, 32'h55, "rxdata 0x55");
    busRead(2'd1, 32'h0000, "status after pop");
    checkOutput("rx_irq after pop", {31'b0, rx_irq}, 32'd0);

    $display("[TB] overrun with five bytes");
    for (int b = 1; b <= 5; b++) sendRxByte(8'(b), 1'b1);
    busRead(2'd1, 32'h0407, "status overrun");
    for (int b = 1; b <= 4; b++) busRead(2'd0, 32'(b), "rxdata fifo order");
    busRead(2'd1, 32'h0004, "status overrun sticky");
    busWrite(2'd1, 32'h4);
    busRead(2'd1, 32'h0000, "status overrun cleared");

    $display("[TB] framing error");
    sendRxByte(8'hA3, 1'b0);
    uart_rx = 1'b1;
    repeat (10) tick();
    busRead(2'd1, 32'h0008, "status frame_err");
    busWrite(2'd1, 32'h8);
    busRead(2'd1, 32'h0000, "status frame_err cleared");

    $display("[TB] glitch rejection");
    uart_rx = 1'b0;
    repeat (3) tick();
    uart_rx = 1'b1;
    repeat (12) tick();
    busRead(2'd1, 32'h0000, "status after glitch");
    sendRxByte(8'h5A, 1'b1);
    busRead(2'd1, 32'h0101, "status after glitch byte");
    busRead(2'd0, 32'h5A, "rxdata after glitch");

    $display("[TB] push with pop on empty fifo");
    fork
      sendRxByte(8'h66, 1'b1);
      begin
        repeat (78) tick();
        busRead(2'd0, 32'h0, "rxdata pop while empty");
      end
    join
    busRead(2'd1, 32'h0101, "status push pop empty");
    busRead(2'd0, 32'h66, "rxdata 0x66");

    $display("[TB] push with pop on full fifo");
    for (int b = 8'h11; b <= 8'h14; b++) sendRxByte(8'(b), 1'b1);
    busRead(2'd1, 32'h0403, "status full");
    fork
      sendRxByte(8'h15, 1'b1);
      begin
        repeat (78) tick();
        busRead(2'd0, 32'h11, "rxdata pop while full");
      end
    join
    busRead(2'd1, 32'h0403, "status full no overrun");
    for (int b = 8'h12; b <= 8'h15; b++) busRead(2'd0, 32'(b), "rxdata after full pop");
    busRead(2'd1, 32'h0000, "status drained");

    $display("[TB] transmit 0xC4");
    txQ.push_back(8'hC4);
    busWrite(2'd2, 32'hC4);
    address = 2'd1;
    #1;
    cnt = 0;
    while (data_out[4] && cnt < 200) begin
      cnt++;
      tick();
    end
    checkOutput("tx_busy cycles", 32'(cnt), 32'd80);
    txQ.push_back(8'hC4);
    busWrite(2'd2, 32'hC4);
    repeat (20) tick();
    busRead(2'd1, 32'h0010, "status tx_busy");
    busRead(2'd2, 32'h0, "txdata reads zero");
    busWrite(2'd2, 32'h3C);
    address = 2'd1;
    #1;
    cnt = 0;
    while (data_out[4] && cnt < 200) begin
      cnt++;
      tick();
    end
    checkOutput("tx second frame ends", {31'b0, data_out[4]}, 32'd0);
    repeat (100) tick();

    $display("[TB] reset during frames");
    sendRxByte(8'h77, 1'b1);
    checkOutput("rx_irq before reset", {31'b0, rx_irq}, 32'd1);
    fork
      sendRxByte(8'h9C, 1'b1);
      begin
        repeat (10) tick();
        busWrite(2'd2, 32'hC4);
        repeat (36) tick();
        reset2 = 1'b1;
        #1;
        checkOutput("uart_tx in reset", {31'b0, uart_tx}, 32'd1);
        checkOutput("rx_irq in reset", {31'b0, rx_irq}, 32'd0);
      end
    join
    repeat (2) tick();
    reset2 = 1'b0;
    repeat (3) tick();
    for (int a = 0; a < 4; a++) busRead(2'(a), 32'h0, "read after reset");
    checkOutput("rx_irq after reset", {31'b0, rx_irq}, 32'd0);
    checkOutput("uart_tx after reset", {31'b0, uart_tx}, 32'd1);
    repeat (60) tick();
  endtask

  initial begin : mainSeq
    applyStimulus();
    for (int n = 0; n < 200 && (expValQ.size() != 0 || txQ.size() != 0); n++) tick();
    checkOutput("pending reads", 32'(expValQ.size()), 32'd0);
    checkOutput("pending tx frames", 32'(txQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
